uart_rx_sink: RTL and testbench



---
 rtl/uart_rx_sink_if.sv | 17 +
 rtl/uart_rx_sink.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_sink.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sink_if.sv
// Byte-stream port of the UART receiver: FWFT head, handshake, occupancy and status flags.
interface uart_rx_sink_if #(
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic [CW-1:0] count;
    logic          ferr;
    logic          ovf;

    // Receiver side drives the stream, consumer side drives ready.
    modport master (output data, valid, count, ferr, ovf, input ready);
    modport slave  (input data, valid, count, ferr, ovf, output ready);
endinterface

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
// Reports framing errors as a one-cycle pulse and FIFO overflow as a sticky flag.
module uart_rx_sink #(
    parameter int unsigned BAUD_DIV = 868,
    parameter int unsigned DEPTH    = 8
) (
    input  logic           xclk,
    input  logic           xres,
    input  logic           uart_rxd,
    uart_rx_sink_if.master rx
);
    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, prev_q;
    logic line, fall;

    // Two sync flops plus a history flop; all idle high so reset never looks like an edge.
    always_ff @(posedge xclk or negedge xres) begin
        if (!xres) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line = sync2_q;
    assign fall = prev_q & ~sync2_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bitc_q, bitc_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_q, push_d;
    logic          bad_q, bad_d;
    logic          ferr_q;

    // FSM state, counters and the registered stop-bit verdict.
    always_ff @(posedge xclk or negedge xres) begin
        if (!xres) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bitc_q  <= '0;
            shreg_q <= '0;
            push_q  <= 1'b0;
            bad_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bitc_q  <= bitc_d;
            shreg_q <= shreg_d;
            push_q  <= push_d;
            bad_q   <= bad_d;
            ferr_q  <= bad_q;
        end
    end

    // Next-state: sample mid-bit whenever the baud down-counter reaches zero.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bitc_d  = bitc_q;
        shreg_d = shreg_q;
        push_d  = 1'b0;
        bad_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    baud_d  = HALF_LOAD;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    if (line) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        baud_d  = FULL_LOAD;
                        bitc_d  = '0;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    shreg_d = {line, shreg_q[7:1]};
                    baud_d  = FULL_LOAD;
                    if (bitc_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bitc_d = bitc_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StStop: begin
                if (baud_q == '0) begin
                    // Back to idle half a bit early so a zero-gap next start is caught.
                    state_d = StIdle;
                    if (line) begin
                        push_d = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic          full, pop, push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && rx.ready;
    // A pop at full frees the slot the push lands in.
    assign push_ok = push_q && (!full || pop);

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge xclk or negedge xres) begin
        if (!xres) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= shreg_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_q && full && !pop) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rx.data  = mem_q[rptr_q];
    assign rx.valid = (count_q != '0);
    assign rx.count = count_q;
    assign rx.ferr  = ferr_q;
    assign rx.ovf   = ovf_q;
endmodule

// File: tb/tb_uart_rx_sink.sv
// Bench for uart_rx_sink: directed corner cases, a vector table and a randomized run,
// all cross-checked every cycle against a frame-level reference model.
module tb_uart_rx_sink;
    localparam int unsigned BAUD  = 16;
    localparam int unsigned DEPTH = 8;
    // Line fall to head visible: 3 sync/detect + half bit + 9 bits + 1.
    localparam int LAT = 3 + BAUD / 2 + 9 * BAUD + 1;

    logic xclk = 1'b0;
    logic xres = 1'b0;
    logic rxd  = 1'b1;

    uart_rx_sink_if #(.DEPTH(DEPTH)) rx_if ();

    uart_rx_sink #(.BAUD_DIV(BAUD), .DEPTH(DEPTH)) dut (
        .xclk    (xclk),
        .xres    (xres),
        .uart_rxd(rxd),
        .rx      (rx_if)
    );

    always #5 xclk = ~xclk;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         good;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop;
        int         gap;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    ev_t        sched[$];
    ev_t        ev;
    logic [7:0] mq[$];
    logic [7:0] dut_pops[$];
    bit         m_ovf, m_ferr;
    bit         mon_en, rand_ready;
    int         cyc, checks, errors, ferr_cnt;

    // Reference model: each frame lands LAT edges after its start; FIFO as a bounded queue.
    always @(posedge xclk) begin
        cyc++;
        if (xres) begin
            m_ferr = 1'b0;
            if (mq.size() != 0 && rx_if.ready) void'(mq.pop_front());
            if (sched.size() != 0 && sched[0].at == cyc) begin
                ev = sched.pop_front();
                if (!ev.good) m_ferr = 1'b1;
                else if (mq.size() < int'(DEPTH)) mq.push_back(ev.b);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model, plus pop/FERR bookkeeping.
    always @(negedge xclk) begin
        if (xres) begin
            logic [7:0] ed;
            bit         ok;
            if (rx_if.ferr) ferr_cnt++;
            if (rx_if.valid && rx_if.ready) dut_pops.push_back(rx_if.data);
            if (mon_en) begin
                ed = (mq.size() != 0) ? mq[0] : 8'h00;
                ok = (rx_if.valid == (mq.size() != 0)) && (int'(rx_if.count) == mq.size())
                     && (rx_if.ferr == m_ferr) && (rx_if.ovf == m_ovf)
                     && (mq.size() == 0 || rx_if.data == ed);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL monitor cyc=%0d valid=%0b/%0b count=%0d/%0d data=%h/%h ferr=%0b/%0b ovf=%0b/%0b",
                             cyc, rx_if.valid, mq.size() != 0, rx_if.count, mq.size(),
                             rx_if.data, ed, rx_if.ferr, m_ferr, rx_if.ovf, m_ovf);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge xclk);
        #1;
        if (rand_ready) rx_if.ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rxd  = 1'b1;
        xres = 1'b0;
        mq.delete();
        sched.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        repeat (3) tick();
        xres = 1'b1;
    endtask

    // Drive one frame; abort_bit >= 0 stops half-way through that frame bit (0 = start).
    task automatic send_frame(input logic [7:0] b, input bit stop, input int abort_bit);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        sched.push_back('{at: cyc + LAT, b: b, good: stop});
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            if (i == abort_bit) begin
                repeat (BAUD / 2) tick();
                return;
            end
            repeat (BAUD) tick();
        end
        rxd = 1'b1;
    endtask

    vec_t       vt[7];
    int         n, f0;
    bit         prev_bad;
    logic [7:0] ob;

    initial begin
        vt[0] = '{b: 8'h12, stop: 1'b1, gap: 0,  exp_valid: 1'b1, exp_data: 8'h12, exp_ferr: 0};
        vt[1] = '{b: 8'h00, stop: 1'b1, gap: 5,  exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 0};
        vt[2] = '{b: 8'hFF, stop: 1'b1, gap: 17, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 0};
        vt[3] = '{b: 8'h80, stop: 1'b1, gap: 3,  exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 0};
        vt[4] = '{b: 8'h01, stop: 1'b1, gap: 9,  exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 0};
        vt[5] = '{b: 8'hC3, stop: 1'b0, gap: 1,  exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1};
        vt[6] = '{b: 8'h7E, stop: 1'b1, gap: 30, exp_valid: 1'b1, exp_data: 8'h7E, exp_ferr: 0};

        rx_if.ready = 1'b0;
        repeat (3) @(posedge xclk);
        #1;
        xres   = 1'b1;
        mon_en = 1'b1;

        // Idle line after reset.
        repeat (20 * BAUD) tick();
        check("idle_valid", 32'(rx_if.valid), 0);
        check("idle_count", 32'(rx_if.count), 0);
        check("idle_ferr_seen", 32'(ferr_cnt), 0);
        check("idle_ovf", 32'(rx_if.ovf), 0);
        check("idle_data", 32'(rx_if.data), 0);

        // Single frame latency.
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                while (!rx_if.valid && n < 400) begin
                    tick();
                    n++;
                end
            end
        join
        check("a5_latency", 32'(n), 32'(LAT));
        check("a5_data", 32'(rx_if.data), 32'h A5);
        check("a5_count", 32'(rx_if.count), 1);
        rx_if.ready = 1'b1;
        tick();
        rx_if.ready = 1'b0;
        check("a5_drained", 32'(rx_if.valid), 0);

        // Back-to-back frames with the consumer always ready.
        dut_pops.delete();
        f0 = ferr_cnt;
        rx_if.ready = 1'b1;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        repeat (2 * BAUD) tick();
        rx_if.ready = 1'b0;
        check("b2b_npops", 32'(dut_pops.size()), 3);
        check("b2b_pop0", (dut_pops.size() > 0) ? 32'(dut_pops[0]) : 32'hx, 32'h00);
        check("b2b_pop1", (dut_pops.size() > 1) ? 32'(dut_pops[1]) : 32'hx, 32'hFF);
        check("b2b_pop2", (dut_pops.size() > 2) ? 32'(dut_pops[2]) : 32'hx, 32'h55);
        check("b2b_ferr", 32'(ferr_cnt - f0), 0);

        // Glitch, then a frame with a bad stop bit.
        f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (5) tick();
        rxd = 1'b1;
        repeat (3 * BAUD) tick();
        check("glitch_count", 32'(rx_if.count), 0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 0);
        send_frame(8'h3C, 1'b0, -1);
        repeat (BAUD) tick();
        check("badstop_ferr", 32'(ferr_cnt - f0), 1);
        check("badstop_count", 32'(rx_if.count), 0);

        // Overflow: nine frames into eight slots.
        for (int i = 0; i < 9; i++) begin
            ob = 8'(i * 17 + 3);
            send_frame(ob, 1'b1, -1);
        end
        repeat (BAUD) tick();
        check("ovf_count", 32'(rx_if.count), 8);
        check("ovf_flag", 32'(rx_if.ovf), 1);
        check("ovf_head", 32'(rx_if.data), 32'h03);
        rx_if.ready = 1'b1;
        repeat (8) tick();
        rx_if.ready = 1'b0;
        check("ovf_empty", 32'(rx_if.valid), 0);
        check("ovf_sticky", 32'(rx_if.ovf), 1);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'h81, 1'b1, 5);
        do_reset();
        check("rst_valid", 32'(rx_if.valid), 0);
        check("rst_count", 32'(rx_if.count), 0);
        check("rst_ovf", 32'(rx_if.ovf), 0);
        check("rst_data", 32'(rx_if.data), 0);
        f0 = ferr_cnt;
        repeat (2 * BAUD) tick();
        send_frame(8'h81, 1'b1, -1);
        repeat (BAUD) tick();
        check("rst_rx_valid", 32'(rx_if.valid), 1);
        check("rst_rx_data", 32'(rx_if.data), 32'h81);
        check("rst_rx_count", 32'(rx_if.count), 1);
        check("rst_rx_ferr", 32'(ferr_cnt - f0), 0);

        // Vector table, FIFO drained before each entry.
        for (int i = 0; i < 7; i++) begin
            rx_if.ready = 1'b1;
            tick();
            tick();
            rx_if.ready = 1'b0;
            f0 = ferr_cnt;
            repeat (vt[i].gap) tick();
            send_frame(vt[i].b, vt[i].stop, -1);
            check($sformatf("vec%0d_valid", i), 32'(rx_if.valid), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(rx_if.data), 32'(vt[i].exp_data));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vt[i].exp_ferr));
        end

        // Randomized bytes, gaps, stop errors and consumer stalls.
        rx_if.ready = 1'b1;
        repeat (4) tick();
        rand_ready = 1'b1;
        prev_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bit good;
            // A bad stop leaves the line low; it must rise before the next start edge.
            repeat ($urandom_range(prev_bad ? 2 : 0, 30)) tick();
            good = ($urandom_range(0, 7) != 0);
            ob = 8'($urandom);
            send_frame(ob, good, -1);
            prev_bad = !good;
        end
        rand_ready  = 1'b0;
        rx_if.ready = 1'b1;
        repeat (2 * BAUD) tick();
        check("rand_drained", 32'(rx_if.valid), 0);
        check("rand_ovf", 32'(rx_if.ovf), 32'(m_ovf));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
